// File: rtl/dmem_bank_arbiter_if.sv
// Requester/memory bundle for dmem_bank_arbiter: two requester ports (A = CPU, B = DMA)
// plus the shared 8-bank data-memory bus. slave = arbiter side, master = environment side.
interface dmem_bank_arbiter_if #(
  parameter int ADDR_W  = 13,
  parameter int BANK_W  = 3,
  parameter int WDATA_W = 32,
  parameter int RDATA_W = 8
);
  localparam int NUM_BANKS = 2**BANK_W;
  localparam int MADDR_W   = ADDR_W - BANK_W;

  logic                 a_req;
  logic                 a_we;
  logic [ADDR_W-1:0]    a_addr;
  logic [WDATA_W-1:0]   a_wdata;
  logic                 a_gnt;
  logic                 a_rvalid;
  logic [RDATA_W-1:0]   a_rdata;

  logic                 b_req;
  logic                 b_we;
  logic [ADDR_W-1:0]    b_addr;
  logic [WDATA_W-1:0]   b_wdata;
  logic                 b_gnt;
  logic                 b_rvalid;
  logic [RDATA_W-1:0]   b_rdata;

  logic [NUM_BANKS-1:0] mem_en;
  logic                 mem_rw;
  logic [MADDR_W-1:0]   mem_addr;
  logic [WDATA_W-1:0]   mem_wdata;
  logic [RDATA_W-1:0]   mem_rdata;
  logic                 busy;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_rvalid, b_rdata,
    output mem_en, mem_rw, mem_addr, mem_wdata, busy,
    input  mem_rdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  mem_en, mem_rw, mem_addr, mem_wdata, busy,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_bank_arbiter.sv
// Two-requester (CPU A / DMA B) arbiter for the banked data memory: IDLE -> ISSUE -> (RESP) -> IDLE.
// Optional grant/conflict statistics counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_bank_arbiter #(
  parameter int ADDR_W    = 13,
  parameter int BANK_W    = 3,
  parameter int WDATA_W   = 32,
  parameter int RDATA_W   = 8,
  parameter int FIXED_PRI = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_bank_arbiter_if.slave    bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]           a_cnt,
  output logic [15:0]           b_cnt,
  output logic [15:0]           conflict_cnt
`endif
);

  localparam int NUM_BANKS = 2**BANK_W;
  localparam int MADDR_W   = ADDR_W - BANK_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  state_e               state_q,     state_d;
  owner_e               owner_q,     owner_d;
  owner_e               last_q,      last_d;
  logic                 we_q,        we_d;
  logic [NUM_BANKS-1:0] mem_en_q,    mem_en_d;
  logic                 mem_rw_q,    mem_rw_d;
  logic [MADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [WDATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                 a_gnt_q,     a_gnt_d;
  logic                 b_gnt_q,     b_gnt_d;
  logic                 a_rv_q,      a_rv_d;
  logic                 b_rv_q,      b_rv_d;
  logic                 busy_q,      busy_d;

  logic                 pick_a;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [WDATA_W-1:0]   sel_wdata;

  function automatic logic [NUM_BANKS-1:0] bank_decode(input logic [BANK_W-1:0] bank);
    logic [NUM_BANKS-1:0] dec;
    for (int i = 0; i < NUM_BANKS; i++) begin
      dec[i] = (bank == BANK_W'(i));
    end
    return dec;
  endfunction

  // A wins a tie under fixed priority, or when B was the last owner in round-robin mode.
  assign pick_a = bus.a_req & (~bus.b_req | (FIXED_PRI != 0) | (last_q == OWN_B));

  assign sel_we    = pick_a ? bus.a_we    : bus.b_we;
  assign sel_addr  = pick_a ? bus.a_addr  : bus.b_addr;
  assign sel_wdata = pick_a ? bus.a_wdata : bus.b_wdata;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    mem_en_d    = '0;
    mem_rw_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    a_gnt_d     = 1'b0;
    b_gnt_d     = 1'b0;
    a_rv_d      = 1'b0;
    b_rv_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.a_req | bus.b_req) begin
          state_d     = S_ISSUE;
          owner_d     = pick_a ? OWN_A : OWN_B;
          last_d      = owner_d;
          we_d        = sel_we;
          mem_en_d    = bank_decode(sel_addr[ADDR_W-1 -: BANK_W]);
          mem_rw_d    = sel_we;
          mem_addr_d  = sel_addr[MADDR_W-1:0];
          mem_wdata_d = sel_wdata;
          a_gnt_d     = pick_a;
          b_gnt_d     = ~pick_a;
        end
      end
      S_ISSUE: begin
        // Reads need one more cycle for the chip to drive mem_rdata.
        if (we_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
          a_rv_d  = (owner_q == OWN_A);
          b_rv_d  = (owner_q == OWN_B);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_A;
      last_q      <= OWN_B;
      we_q        <= 1'b0;
      mem_en_q    <= '0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      a_gnt_q     <= 1'b0;
      b_gnt_q     <= 1'b0;
      a_rv_q      <= 1'b0;
      b_rv_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      a_gnt_q     <= a_gnt_d;
      b_gnt_q     <= b_gnt_d;
      a_rv_q      <= a_rv_d;
      b_rv_q      <= b_rv_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_rw    = mem_rw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.a_gnt     = a_gnt_q;
  assign bus.b_gnt     = b_gnt_q;
  assign bus.a_rvalid  = a_rv_q;
  assign bus.b_rvalid  = b_rv_q;
  assign bus.busy      = busy_q;

  // Read data is a passthrough of the shared bus, gated to the owner only during its rvalid cycle.
  assign bus.a_rdata = a_rv_q ? bus.mem_rdata : '0;
  assign bus.b_rdata = b_rv_q ? bus.mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] a_cnt_q;
  logic [15:0] b_cnt_q;
  logic [15:0] conflict_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      a_cnt_q        <= '0;
      b_cnt_q        <= '0;
      conflict_cnt_q <= '0;
    end else begin
      if (a_gnt_q) a_cnt_q <= sat_inc(a_cnt_q);
      if (b_gnt_q) b_cnt_q <= sat_inc(b_cnt_q);
      if ((state_q == S_IDLE) && bus.a_req && bus.b_req) begin
        conflict_cnt_q <= sat_inc(conflict_cnt_q);
      end
    end
  end

  assign a_cnt        = a_cnt_q;
  assign b_cnt        = b_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_bank_arbiter.sv
// Directed bench for dmem_bank_arbiter: round-robin instance plus a fixed-priority instance.
// Statistics checks are compiled only when DMEM_ARB_STATS_EN is defined.
module tb_dmem_bank_arbiter;

  logic clk;
  logic reset;
  logic [7:0] model_byte;
  int vectors;
  int miscompares;

  dmem_bank_arbiter_if bus ();
  dmem_bank_arbiter_if bus_fx ();

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] a_cnt, b_cnt, conflict_cnt;
  logic [15:0] fx_a_cnt, fx_b_cnt, fx_conflict_cnt;
`endif

  dmem_bank_arbiter #(.FIXED_PRI(0)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus)
`ifdef DMEM_ARB_STATS_EN
    ,
    .a_cnt        (a_cnt),
    .b_cnt        (b_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  dmem_bank_arbiter #(.FIXED_PRI(1)) u_fix (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus_fx)
`ifdef DMEM_ARB_STATS_EN
    ,
    .a_cnt        (fx_a_cnt),
    .b_cnt        (fx_b_cnt),
    .conflict_cnt (fx_conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: a read issued this cycle drives model_byte on the bus in the next cycle.
  always @(posedge clk) begin
    bus.mem_rdata    <= (|bus.mem_en && !bus.mem_rw) ? model_byte : 8'h00;
    bus_fx.mem_rdata <= (|bus_fx.mem_en && !bus_fx.mem_rw) ? 8'h3C : 8'h00;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    bus_fx.a_req = 0; bus_fx.a_we = 0; bus_fx.a_addr = '0; bus_fx.a_wdata = '0;
    bus_fx.b_req = 0; bus_fx.b_we = 0; bus_fx.b_addr = '0; bus_fx.b_wdata = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // Waits (bounded) for the next grant on one instance; ok=0 when the budget expires.
  task automatic wait_grant(input bit fx, output bit got_a, output bit got_b, output bit ok);
    got_a = 0; got_b = 0; ok = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      got_a = fx ? bus_fx.a_gnt : bus.a_gnt;
      got_b = fx ? bus_fx.b_gnt : bus.b_gnt;
      if (got_a || got_b) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    idle_inputs;
    model_byte = 8'hA5;
    do_reset;
    tick;
    vectors++;
    if ({bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.mem_rw, bus.busy} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.mem_rw, bus.busy});
    end
    vectors++;
    if ({bus.mem_en, bus.mem_addr, bus.mem_wdata, bus.a_rdata, bus.b_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: got en=%h addr=%h wd=%h ard=%h brd=%h expected all 0",
               bus.mem_en, bus.mem_addr, bus.mem_wdata, bus.a_rdata, bus.b_rdata);
    end
    // Start a read, then reset while it is in flight.
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 13'h0801;
    tick;
    vectors++;
    if (bus.a_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pre_gnt: got a_gnt=%b expected 1", bus.a_gnt);
    end
    bus.a_req = 0;
    reset = 1'b1;
    tick;
    vectors++;
    if ({bus.a_rvalid, bus.mem_en, bus.busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_read: got rvalid=%b en=%h busy=%b expected 0 00 0",
               bus.a_rvalid, bus.mem_en, bus.busy);
    end
    tick;
    reset = 1'b0;
    tick;
    vectors++;
    if ({bus.a_rvalid, bus.a_rdata, bus.mem_en, bus.busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_release: got rvalid=%b rdata=%h en=%h busy=%b expected 0 00 00 0",
               bus.a_rvalid, bus.a_rdata, bus.mem_en, bus.busy);
    end
  endtask

  task automatic test_read_b;
    model_byte = 8'h5A;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 13'h0403;
    tick;
    vectors++;
    if ({bus.b_gnt, bus.a_gnt, bus.mem_en, bus.mem_addr, bus.mem_rw} !== {1'b1, 1'b0, 8'h02, 10'h003, 1'b0}) begin
      miscompares++;
      $display("FAIL read_b_issue: got bgnt=%b agnt=%b en=%h addr=%h rw=%b expected 1 0 02 003 0",
               bus.b_gnt, bus.a_gnt, bus.mem_en, bus.mem_addr, bus.mem_rw);
    end
    bus.b_req = 0;
    tick;
    vectors++;
    if ({bus.b_rvalid, bus.b_rdata, bus.a_rvalid, bus.a_rdata, bus.mem_en} !== {1'b1, 8'h5A, 1'b0, 8'h00, 8'h00}) begin
      miscompares++;
      $display("FAIL read_b_resp: got brv=%b brd=%h arv=%b ard=%h en=%h expected 1 5a 0 00 00",
               bus.b_rvalid, bus.b_rdata, bus.a_rvalid, bus.a_rdata, bus.mem_en);
    end
    tick;
    vectors++;
    if ({bus.b_rvalid, bus.b_rdata, bus.busy} !== '0) begin
      miscompares++;
      $display("FAIL read_b_done: got brv=%b brd=%h busy=%b expected 0 00 0",
               bus.b_rvalid, bus.b_rdata, bus.busy);
    end
  endtask

  task automatic test_write_a;
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 13'h1C05; bus.a_wdata = 32'hDEADBEEF;
    tick;
    vectors++;
    if ({bus.a_gnt, bus.mem_en, bus.mem_addr, bus.mem_rw, bus.mem_wdata, bus.busy} !==
        {1'b1, 8'h80, 10'h005, 1'b1, 32'hDEADBEEF, 1'b1}) begin
      miscompares++;
      $display("FAIL write_a_issue: got gnt=%b en=%h addr=%h rw=%b wd=%h busy=%b expected 1 80 005 1 deadbeef 1",
               bus.a_gnt, bus.mem_en, bus.mem_addr, bus.mem_rw, bus.mem_wdata, bus.busy);
    end
    vectors++;
    if ({bus.b_gnt, bus.b_rvalid, bus.b_rdata} !== '0) begin
      miscompares++;
      $display("FAIL write_a_b_quiet: got bgnt=%b brv=%b brd=%h expected 0 0 00",
               bus.b_gnt, bus.b_rvalid, bus.b_rdata);
    end
    bus.a_req = 0; bus.a_we = 0;
    tick;
    vectors++;
    if ({bus.a_gnt, bus.a_rvalid, bus.mem_en, bus.busy} !== '0) begin
      miscompares++;
      $display("FAIL write_a_idle: got gnt=%b rv=%b en=%h busy=%b expected 0 0 00 0",
               bus.a_gnt, bus.a_rvalid, bus.mem_en, bus.busy);
    end
  endtask

  task automatic test_round_robin;
    bit ga, gb, ok;
    // The previous access was owned by A; reset must restore last_owner = B so A wins first.
    do_reset;
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 13'h0010;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 13'h1811;
    for (int k = 0; k < 4; k++) begin
      wait_grant(1'b0, ga, gb, ok);
      vectors++;
      if (!ok || ga !== (k % 2 == 0) || gb !== (k % 2 == 1)) begin
        miscompares++;
        $display("FAIL rr_grant%0d: got a=%b b=%b ok=%b expected a=%b b=%b",
                 k, ga, gb, ok, (k % 2 == 0), (k % 2 == 1));
      end
    end
    bus.a_req = 0; bus.b_req = 0;
    tick; tick; tick;
  endtask

  task automatic test_fixed_pri;
    bit ga, gb, ok;
    do_reset;
    bus_fx.a_req = 1; bus_fx.a_we = 0; bus_fx.a_addr = 13'h0C01;
    bus_fx.b_req = 1; bus_fx.b_we = 0; bus_fx.b_addr = 13'h1402;
    for (int k = 0; k < 3; k++) begin
      wait_grant(1'b1, ga, gb, ok);
      vectors++;
      if (!ok || ga !== 1'b1 || gb !== 1'b0) begin
        miscompares++;
        $display("FAIL fix_grant%0d: got a=%b b=%b ok=%b expected a=1 b=0", k, ga, gb, ok);
      end
      if (ok && ga) begin
        vectors++;
        if (bus_fx.mem_en !== 8'h08) begin
          miscompares++;
          $display("FAIL fix_en%0d: got %h expected 08", k, bus_fx.mem_en);
        end
      end
    end
    bus_fx.a_req = 0;
    wait_grant(1'b1, ga, gb, ok);
    vectors++;
    if (!ok || ga !== 1'b0 || gb !== 1'b1 || bus_fx.mem_en !== 8'h20) begin
      miscompares++;
      $display("FAIL fix_b_after_a_drop: got a=%b b=%b ok=%b en=%h expected a=0 b=1 en=20",
               ga, gb, ok, bus_fx.mem_en);
    end
    bus_fx.b_req = 0;
    tick; tick; tick;
  endtask

`ifdef DMEM_ARB_STATS_EN
  task automatic test_stats;
    bit ga, gb, ok;
    do_reset;
    tick;
    vectors++;
    if ({a_cnt, b_cnt, conflict_cnt} !== '0) begin
      miscompares++;
      $display("FAIL stats_reset: got %h %h %h expected 0 0 0", a_cnt, b_cnt, conflict_cnt);
    end
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 13'h0020;
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 13'h0021;
    for (int k = 0; k < 4; k++) wait_grant(1'b0, ga, gb, ok);
    bus.a_req = 0; bus.b_req = 0;
    tick; tick;
    bus.a_req = 1; bus.a_we = 1;
    wait_grant(1'b0, ga, gb, ok);
    bus.a_req = 0; bus.a_we = 0;
    tick; tick;
    vectors++;
    if ({a_cnt, b_cnt, conflict_cnt} !== {16'd3, 16'd2, 16'd4}) begin
      miscompares++;
      $display("FAIL stats_counts: got a=%0d b=%0d c=%0d expected 3 2 4", a_cnt, b_cnt, conflict_cnt);
    end
    force u_dut.a_cnt_q = 16'hFFFE;
    force u_dut.conflict_cnt_q = 16'hFFFF;
    #1;
    release u_dut.a_cnt_q;
    release u_dut.conflict_cnt_q;
    bus.a_req = 1; bus.b_req = 1;
    wait_grant(1'b0, ga, gb, ok);
    bus.a_req = 0; bus.b_req = 0;
    tick; tick;
    bus.a_req = 1; bus.a_we = 1;
    wait_grant(1'b0, ga, gb, ok);
    bus.a_req = 0; bus.a_we = 0;
    tick; tick;
    vectors++;
    if ({a_cnt, conflict_cnt} !== {16'hFFFF, 16'hFFFF}) begin
      miscompares++;
      $display("FAIL stats_saturate: got a=%h c=%h expected ffff ffff", a_cnt, conflict_cnt);
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    model_byte = 8'h00;
    idle_inputs;
    test_reset;
    test_read_b;
    test_write_a;
    test_round_robin;
    test_fixed_pri;
`ifdef DMEM_ARB_STATS_EN
    test_stats;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
